// File: rtl/dcache_controller.sv
// Miss-handling controller for a 2-way, 16-set write-back data cache with 256-bit lines.
// Hits finish in the access cycle; misses write back a dirty victim and then refill over mem req/ack.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  input  logic         sram_hit_i,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS      = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_REFILL    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [255:0]  victim_line_q, victim_line_d;
  logic [31:0]   victim_addr_q, victim_addr_d;
  logic          gap_q, gap_d;

  logic [7:0]    word_bit;
  logic [255:0]  merged_line;
  logic          victim_dirty;
  logic          unused_addr_bits;

  assign word_bit         = {cpu_addr_i[4:2], 5'b0};
  assign victim_dirty     = sram_tag_i[24] & sram_tag_i[23];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign sram_addr_o   = cpu_addr_i[8:5];
  assign sram_enable_o = cpu_req_i;
  assign cpu_data_o    = sram_data_i[word_bit +: 32];
  assign cpu_stall_o   = cpu_req_i & ((state_q != S_IDLE) | ~sram_hit_i);
  assign mem_data_o    = victim_line_q;

  always_comb begin
    merged_line = sram_data_i;
    merged_line[word_bit +: 32] = cpu_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      victim_line_q <= '0;
      victim_addr_q <= '0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      victim_line_q <= victim_line_d;
      victim_addr_q <= victim_addr_d;
      gap_q         <= gap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    victim_line_d = victim_line_q;
    victim_addr_d = victim_addr_q;
    gap_d         = gap_q;
    sram_write_o  = 1'b0;
    sram_data_o   = merged_line;
    sram_tag_o    = {2'b11, cpu_addr_i[31:9]};
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = {cpu_addr_i[31:5], 5'b0};

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          if (sram_hit_i) sram_write_o = cpu_write_i;
          else            state_d      = S_MISS;
        end
      end
      S_MISS: begin
        gap_d = 1'b0;
        if (victim_dirty) begin
          victim_line_d = sram_data_i;
          victim_addr_d = {sram_tag_i[22:0], cpu_addr_i[8:5], 5'b0};
          state_d       = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = victim_addr_q;
        if (mem_ack_i) begin
          state_d = S_ALLOCATE;
          gap_d   = 1'b1;
        end
      end
      S_ALLOCATE: begin
        // First ALLOCATE cycle after a write-back idles the bus so the two requests are distinct.
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          mem_enable_o = 1'b1;
          if (mem_ack_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = mem_data_i;
            sram_tag_o   = {2'b10, cpu_addr_i[31:9]};
            state_d      = S_REFILL;
          end
        end
      end
      S_REFILL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural 2-way SRAM and line memory around the DUT,
// directed vector table plus random accesses checked against a flat-memory/LRU reference.
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst_i, cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, sram_enable_o, sram_write_o, sram_hit_i;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i, mem_data_o, mem_data_i;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_hit_i(sram_hit_i),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, viol = 0, sram_wr_total = 0, lat = 3, mem_cnt = 0, cur_way = 0;
  bit spurious = 0, gap_expected = 0;

  logic [31:0]  ref_mem  [1024];
  logic [255:0] line_mem [128];
  logic [24:0]  s_tag  [2][16];
  logic [255:0] s_data [2][16];
  bit           s_lru  [16];
  logic [22:0]  m_tag [16][2];
  bit           m_v [16][2];
  bit           m_d [16][2];

  typedef struct packed { bit wr; logic [31:0] addr; } mlog_t;
  mlog_t mem_log[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_stall;
    bit          exp_wb;
    logic [31:0] wb_addr;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic settle_sram();
    logic [3:0] s;
    logic [22:0] t;
    bit h0, h1;
    s  = cpu_addr_i[8:5];
    t  = cpu_addr_i[31:9];
    h0 = s_tag[0][s][24] && (s_tag[0][s][22:0] == t);
    h1 = s_tag[1][s][24] && (s_tag[1][s][22:0] == t);
    cur_way     = h0 ? 0 : (h1 ? 1 : int'(s_lru[s]));
    sram_hit_i  = h0 | h1;
    sram_tag_i  = s_tag[cur_way][s];
    sram_data_i = s_data[cur_way][s];
  endtask

  // One clock: capture pre-edge activity, update SRAM/memory models, drive next responses.
  task automatic tick();
    bit do_w, touch, done, mw, ack;
    int w;
    logic [3:0] s;
    logic [24:0] tv;
    logic [255:0] dv, md;
    logic [31:0] ma;
    mlog_t e;
    do_w  = sram_enable_o && sram_write_o;
    touch = sram_enable_o && sram_hit_i && !cpu_stall_o;
    w = cur_way; s = sram_addr_o; tv = sram_tag_o; dv = sram_data_o;
    done = mem_enable_o && mem_ack_i;
    mw = mem_write_o; ma = mem_addr_o; md = mem_data_o;
    if (cpu_stall_o && sram_write_o && !(done && !mw)) viol++;
    if (done && !mw && (!sram_write_o || sram_tag_o[24:23] != 2'b10)) viol++;
    if (gap_expected && mem_enable_o) viol++;
    if (mem_enable_o && mem_addr_o[4:0] != 5'd0) viol++;
    gap_expected = done && mw;
    @(posedge clk);
    if (do_w) begin
      s_tag[w][s] = tv; s_data[w][s] = dv; s_lru[s] = (w == 0); sram_wr_total++;
    end
    if (touch) s_lru[s] = (w == 0);
    if (done) begin
      e.wr = mw; e.addr = ma; mem_log.push_back(e);
      if (mw) line_mem[ma[11:5]] = md;
    end
    #1;
    ack = 0;
    if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin ack = 1; mem_cnt = 0; end
    end else begin
      mem_cnt = 0;
    end
    mem_ack_i  = ack | spurious;
    mem_data_i = (ack && !mem_write_o) ? line_mem[mem_addr_o[11:5]] : {8{$urandom()}};
    settle_sram();
    #1;
  endtask

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls, output bit hw, output logic [1:0] htag);
    cpu_req_i = 1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
    settle_sram(); #1;
    stalls = 0;
    while (cpu_stall_o && stalls < 200) begin tick(); stalls++; end
    if (stalls >= 200) begin
      total++; bad++;
      $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", a, stalls);
    end
    rd = cpu_data_o; hw = sram_write_o; htag = sram_tag_o[24:23];
    tick();
    cpu_req_i = 0; cpu_write_i = 0;
    settle_sram(); #1;
  endtask

  // Reference: 2-way LRU set model, slot 0 = most recent. Returns expected stall cycles.
  function automatic int predict(input bit wr, input logic [31:0] a, input int l);
    logic [3:0] s;
    logic [22:0] t, tt;
    bit td;
    int pen;
    s = a[8:5]; t = a[31:9];
    if (m_v[s][0] && m_tag[s][0] == t) begin
      m_d[s][0] = m_d[s][0] | wr;
      return 0;
    end
    if (m_v[s][1] && m_tag[s][1] == t) begin
      tt = m_tag[s][0]; td = m_d[s][0];
      m_tag[s][0] = t; m_d[s][0] = m_d[s][1] | wr;
      m_tag[s][1] = tt; m_d[s][1] = td; m_v[s][1] = 1;
      return 0;
    end
    pen = (m_v[s][1] && m_d[s][1]) ? 4 + 2 * l : 3 + l;
    m_tag[s][1] = m_tag[s][0]; m_d[s][1] = m_d[s][0]; m_v[s][1] = m_v[s][0];
    m_tag[s][0] = t; m_d[s][0] = wr; m_v[s][0] = 1;
    return pen;
  endfunction

  initial begin
    logic [31:0] rd, a, d;
    int st, n, wr0, exp_st, exp_n;
    bit hw, wr;
    logic [1:0] htag;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA500_0000 + i;
    ref_mem[32'h48 >> 2] = 32'hDEAD_BEEF;
    for (int l = 0; l < 128; l++)
      for (int k = 0; k < 8; k++) line_mem[l][32*k +: 32] = ref_mem[l*8 + k];
    for (int s = 0; s < 16; s++) begin
      s_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        s_tag[w][s] = '0; s_data[w][s] = '0;
        m_v[s][w] = 0; m_d[s][w] = 0; m_tag[s][w] = '0;
      end
    end

    tbl[0] = '{0, 32'h048, 32'h0,         32'hDEAD_BEEF, 6,  0, 32'h0};
    tbl[1] = '{1, 32'h044, 32'h1234_5678, 32'h0,         0,  0, 32'h0};
    tbl[2] = '{0, 32'h044, 32'h0,         32'h1234_5678, 0,  0, 32'h0};
    tbl[3] = '{0, 32'h240, 32'h0,         32'hA500_0090, 6,  0, 32'h0};
    tbl[4] = '{0, 32'h440, 32'h0,         32'hA500_0110, 10, 1, 32'h40};
    tbl[5] = '{0, 32'h044, 32'h0,         32'h1234_5678, 6,  0, 32'h0};
    tbl[6] = '{0, 32'h048, 32'h0,         32'hDEAD_BEEF, 0,  0, 32'h0};
    tbl[7] = '{1, 32'h05C, 32'h0BAD_C0DE, 32'h0,         0,  0, 32'h0};
    tbl[8] = '{0, 32'h05C, 32'h0,         32'h0BAD_C0DE, 0,  0, 32'h0};

    rst_i = 1; cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    mem_ack_i = 0; mem_data_i = '0;
    settle_sram();
    #11;
    chk("reset_mem_enable", {31'd0, mem_enable_o}, 0);
    chk("reset_mem_write",  {31'd0, mem_write_o}, 0);
    chk("reset_sram_write", {31'd0, sram_write_o}, 0);
    chk("reset_stall",      {31'd0, cpu_stall_o}, 0);
    #1 rst_i = 0;
    tick();

    lat = 3;
    for (int i = 0; i < 9; i++) begin
      mem_log.delete();
      st = predict(tbl[i].wr, tbl[i].addr, lat);
      access(tbl[i].wr, tbl[i].addr, tbl[i].data, rd, n, hw, htag);
      $display("vec %0d: %s addr=%h rd=%h stall=%0d", i, tbl[i].wr ? "st" : "ld", tbl[i].addr, rd, n);
      chk($sformatf("vec%0d_stall", i), n, tbl[i].exp_stall);
      if (tbl[i].wr) begin
        ref_mem[tbl[i].addr[11:2]] = tbl[i].data;
        chk($sformatf("vec%0d_hit_sram_write", i), {31'd0, hw}, 1);
        chk($sformatf("vec%0d_hit_tag_vd", i), {30'd0, htag}, 2'b11);
      end else begin
        chk($sformatf("vec%0d_load_data", i), rd, tbl[i].exp_rd);
        chk($sformatf("vec%0d_load_no_write", i), {31'd0, hw}, 0);
      end
      exp_n = (tbl[i].exp_stall == 0) ? 0 : (tbl[i].exp_wb ? 2 : 1);
      chk($sformatf("vec%0d_mem_txns", i), mem_log.size(), exp_n);
      if (mem_log.size() == exp_n && exp_n > 0) begin
        if (tbl[i].exp_wb) begin
          chk($sformatf("vec%0d_wb_write", i), {31'd0, mem_log[0].wr}, 1);
          chk($sformatf("vec%0d_wb_addr", i), mem_log[0].addr, tbl[i].wb_addr);
        end
        chk($sformatf("vec%0d_fill_write", i), {31'd0, mem_log[exp_n-1].wr}, 0);
        chk($sformatf("vec%0d_fill_addr", i), mem_log[exp_n-1].addr, {tbl[i].addr[31:5], 5'd0});
      end
    end

    // Spurious ack while idle must be ignored.
    wr0 = sram_wr_total;
    spurious = 1;
    tick();
    chk("spur_sram_write", {31'd0, sram_write_o}, 0);
    chk("spur_mem_enable", {31'd0, mem_enable_o}, 0);
    spurious = 0;
    tick();
    chk("spur_no_sram_wr", sram_wr_total, wr0);
    access(0, 32'h48, 0, rd, n, hw, htag);
    $display("spurious follow-up: rd=%h stall=%0d", rd, n);
    chk("spur_follow_stall", n, 0);
    chk("spur_follow_data", rd, 32'hDEAD_BEEF);

    // Reset while ALLOCATE waits for its ack.
    lat = 10;
    cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h840;
    settle_sram(); #1;
    n = 0;
    while (!(mem_enable_o && !mem_write_o) && n < 20) begin tick(); n++; end
    chk("rst_alloc_reached", {31'd0, mem_enable_o && !mem_write_o}, 1);
    chk("rst_alloc_addr", mem_addr_o, 32'h840);
    tick(); tick();
    wr0 = sram_wr_total;
    #2 rst_i = 1;
    #1;
    chk("rst_mid_mem_enable", {31'd0, mem_enable_o}, 0);
    chk("rst_mid_sram_write", {31'd0, sram_write_o}, 0);
    cpu_req_i = 0;
    settle_sram(); #1;
    chk("rst_mid_stall", {31'd0, cpu_stall_o}, 0);
    tick();
    #2 rst_i = 0;
    tick();
    chk("rst_mid_no_sram_wr", sram_wr_total, wr0);
    $display("reset during allocate: mem_enable=%0d sram_writes=%0d", mem_enable_o, sram_wr_total - wr0);
    lat = 3;
    access(0, 32'h5C, 0, rd, n, hw, htag);
    chk("rst_after_stall", n, 0);
    chk("rst_after_data", rd, 32'h0BAD_C0DE);

    // Random traffic against the flat memory and LRU reference.
    for (int i = 0; i < 250; i++) begin
      lat = $urandom_range(1, 4);
      wr  = ($urandom() % 2) == 1;
      a   = ($urandom_range(0, 7) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      d   = $urandom();
      exp_st = predict(wr, a, lat);
      access(wr, a, d, rd, n, hw, htag);
      $display("rnd %0d: %s addr=%h lat=%0d rd=%h stall=%0d", i, wr ? "st" : "ld", a, lat, rd, n);
      chk("rnd_stall", n, exp_st);
      if (wr) ref_mem[a[11:2]] = d;
      else    chk("rnd_load_data", rd, ref_mem[a[11:2]]);
    end

    chk("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- FSM that drives the 2-way dcache SRAM (16 sets, 256-bit lines, 25-bit tag words) on behalf of the CPU load/store port.
- Hits complete with no added latency.
- Misses stall the CPU, write back a dirty victim when one exists, then refill the line from data memory over a req/ack handshake.
- Sits between the CPU MEM stage, the dcache SRAM and the off-chip data memory.

Parameters:
- None. Geometry is fixed: 32-bit byte address; offset [4:0]; index [8:5] (16 sets); tag [31:9] (23 bits).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cpu_req_i  in  1  CPU access request
cpu_write_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address
cpu_data_i  in  32  store data
cpu_data_o  out  32  load data
cpu_stall_o  out  1  CPU must hold the request
sram_enable_o  out  1  SRAM enable
sram_write_o  out  1  SRAM write strobe
sram_addr_o  out  4  set index
sram_tag_o  out  25  {valid, dirty, tag[22:0]}
sram_data_o  out  256  line to SRAM
sram_hit_i  in  1  SRAM hit
sram_tag_i  in  25  selected way tag (hit way, else LRU victim)
sram_data_i  in  256  selected way data
mem_enable_o  out  1  memory request, held until ack
mem_write_o  out  1  1 = write-back, 0 = refill read
mem_addr_o  out  32  line address, [4:0] = 0
mem_data_o  out  256  write-back line
mem_data_i  in  256  refill line, valid while mem_ack_i = 1
mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Reset (async, rst_i high):
  - state = IDLE; victim line and victim address registers cleared.
  - mem_enable_o = 0, mem_write_o = 0, sram_write_o = 0; cpu_stall_o = 0 when cpu_req_i = 0.
  - Reset mid-miss abandons the transaction; no SRAM write occurs.
- Static SRAM drive:
  - sram_addr_o = cpu_addr_i[8:5].
  - sram_tag_o[22:0] = cpu_addr_i[31:9].
  - sram_enable_o = cpu_req_i.
- Load data: cpu_data_o = sram_data_i[32*w +: 32], where w = cpu_addr_i[4:2]. Combinational; valid when stall is low.
- Stall: cpu_stall_o = cpu_req_i & ((state != IDLE) | ~sram_hit_i). Combinational. The CPU holds addr, data and write stable while stalled.
- IDLE:
  - Load hit: no SRAM write; stall low the same cycle.
  - Store hit: sram_write_o = 1 the same cycle.
    - sram_data_o = sram_data_i with word w replaced by cpu_data_i.
    - sram_tag_o[24:23] = 2'b11.
  - Miss: go to MISS.
- MISS (1 cycle):
  - Victim dirty (sram_tag_i[24] & sram_tag_i[23]):
    - Latch sram_data_i into the victim line register.
    - Latch {sram_tag_i[22:0], index, 5'b0} into the victim address register.
    - Go to WRITEBACK.
  - Otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1; mem_addr_o and mem_data_o come from the latched victim registers.
  - On mem_ack_i: go to ALLOCATE. mem_enable_o drops for exactly one cycle between the two transactions.
- ALLOCATE:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {cpu_addr_i[31:5], 5'b0}.
  - On mem_ack_i, the same cycle:
    - sram_write_o = 1, sram_data_o = mem_data_i, sram_tag_o[24:23] = 2'b10 (clean, valid).
    - Go to REFILL.
- REFILL (1 cycle): no SRAM write; go to IDLE. The request replays as a hit, so a store merges and sets dirty on replay.
- mem_enable_o is low in IDLE, MISS and REFILL. mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Victim way selection belongs to the SRAM. The controller keeps index and tag stable across the whole miss so the selected way does not change.
- cpu_req_i dropping mid-miss is illegal; behaviour is undefined.
- Worst-case miss penalty = 1 + (writeback latency + 1) + (refill latency + 1) + 1 cycles.

Test Plan:
- Reset, then load 0x0000_0040 on a clean cache:
  - Expect MISS then ALLOCATE with mem_addr_o = 0x40, mem_write_o = 0.
  - Return ack with line word2 = 0xDEADBEEF after 3 cycles; replay load 0x48 -> cpu_data_o = 0xDEADBEEF, stall low.
- Store 0x1234_5678 to 0x44 after that fill:
  - Single-cycle hit, sram_write_o = 1, sram_tag_o[24:23] = 11.
  - Then load 0x44 -> 0x12345678.
- Fill 0x040 and 0x240 (same set 2) and dirty 0x040; access 0x440:
  - Expect WRITEBACK mem_addr_o = 0x40 carrying the dirty line, then ALLOCATE mem_addr_o = 0x440.
  - No SRAM write before the refill ack.
- Clean victim miss -> no write-back; mem_write_o stays 0; total stall = refill latency + 3 cycles.
- Assert rst_i during ALLOCATE before ack -> mem_enable_o = 0 immediately, state IDLE, SRAM contents unchanged.
- Spurious mem_ack_i in IDLE -> no state change, no SRAM write.
